// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: queues upstream samples in a small circular FIFO,
// hands them to the FIR one at a time, and holds each FIR result until
// downstream takes it. Only one sample is ever in flight through the FIR.
module fir_sample_feeder #(
  parameter int inwidth  = 16,
  parameter int outwidth = 38,
  parameter int depth    = 8,
  parameter int logdepth = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [inwidth-1:0]  wr_data,
  output logic                full,
  output logic [logdepth:0]   count,
  output logic                overflow,
  output logic [inwidth-1:0]  fir_in,
  output logic                fir_valid,
  input  logic                fir_ready,
  input  logic [outwidth-1:0] fir_out,
  input  logic                fir_out_valid,
  output logic [outwidth-1:0] res_data,
  output logic                res_valid,
  input  logic                res_ready
);

  localparam logic [logdepth:0] DEPTH_C = (logdepth+1)'(depth);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, HOLD} state_t;

  state_t               state, state_nxt;
  logic [inwidth-1:0]   mem [depth];
  logic [logdepth-1:0]  rd_ptr, wr_ptr;
  logic                 pop, push;

  // The head of the FIFO is what the FIR sees; rd_ptr only moves on a pop,
  // so fir_in stays stable for the whole SEND phase.
  assign fir_in = mem[rd_ptr];
  assign full   = (count == DEPTH_C);
  assign pop    = fir_valid && fir_ready;
  // A pop in the same cycle frees a slot, so a write at full still lands.
  assign push   = wr_en && (!full || pop);

  // Sample storage; contents are don't-care after reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + logdepth'(1);
      if (pop)  rd_ptr <= rd_ptr + logdepth'(1);
      case ({push, pop})
        2'b10:   count <= count + (logdepth+1)'(1);
        2'b01:   count <= count - (logdepth+1)'(1);
        default: count <= count;
      endcase
      if (wr_en && !push) overflow <= 1'b1;
    end
  end

  // State register and result holding register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      res_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == WAIT && fir_out_valid) res_data <= fir_out;
    end
  end

  // Next-state and handshake outputs. Decisions use the registered count,
  // so a sample written this cycle is seen one cycle later.
  always_comb begin
    state_nxt = state;
    fir_valid = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: if (count != '0) state_nxt = SEND;
      SEND: begin
        fir_valid = 1'b1;
        if (fir_ready) state_nxt = WAIT;
      end
      WAIT: if (fir_out_valid) state_nxt = HOLD;
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = (count != '0) ? SEND : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Scoreboard bench for fir_sample_feeder: samples queued on write are
// compared at the FIR handshake, FIR results queued when pulsed are
// compared at the downstream handshake.
module tb_fir_sample_feeder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        full;
  logic [3:0]  count;
  logic        overflow;
  logic [15:0] fir_in;
  logic        fir_valid;
  logic        fir_ready = 1'b0;
  logic [37:0] fir_out = '0;
  logic        fir_out_valid = 1'b0;
  logic [37:0] res_data;
  logic        res_valid;
  logic        res_ready = 1'b1;

  fir_sample_feeder dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .count(count), .overflow(overflow),
    .fir_in(fir_in), .fir_valid(fir_valid), .fir_ready(fir_ready),
    .fir_out(fir_out), .fir_out_valid(fir_out_valid),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clock = ~clock;

  int          nvec = 0;
  int          nerr = 0;
  logic [15:0] sq[$];
  logic [37:0] rq[$];
  int          mcount = 0;
  bit          moverflow = 0;
  int          fwait = -1;
  logic [37:0] fpend = '0;
  bit          rand_fir = 0;
  bit          use_next = 0;
  logic [37:0] next_fout = '0;
  bit          stray = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_en = 1'b0; fir_out_valid = 1'b0;
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    sq.delete(); rq.delete();
    mcount = 0; moverflow = 0; fwait = -1; use_next = 0; stray = 0;
  endtask

  // One clock: drive the FIR model, score handshakes, advance, check state.
  task automatic tick();
    bit pop, pushed, pulsed, hold_rel;
    pulsed = 0;
    if (stray) begin
      fir_out_valid = 1'b1; fir_out = 38'h3F_DEAD_BEEF; stray = 0;
    end else if (fwait == 0) begin
      fir_out_valid = 1'b1; fir_out = fpend; rq.push_back(fpend);
      fwait = -1; pulsed = 1;
    end else begin
      fir_out_valid = 1'b0;
      if (fwait > 0) fwait--;
    end
    pop = fir_valid && fir_ready;
    if (pop) begin
      if (sq.size() == 0) check("fir_in_unexpected", 1, 0);
      else check("fir_in", fir_in, sq.pop_front());
      fpend = use_next ? next_fout : {fir_in, ~fir_in, 6'h15};
      use_next = 0;
      fwait = rand_fir ? int'($urandom_range(0, 3)) : 2;
    end
    hold_rel = res_valid && res_ready && (mcount != 0);
    if (res_valid && res_ready) begin
      if (rq.size() == 0) check("res_unexpected", 1, 0);
      else check("res_data", res_data, rq.pop_front());
    end
    pushed = wr_en && (mcount < 8 || pop);
    if (wr_en && !pushed) moverflow = 1;
    if (pushed) sq.push_back(wr_data);
    mcount = mcount + int'(pushed) - int'(pop);
    @(posedge clock); @(negedge clock);
    check("count", count, mcount);
    check("full", full, mcount == 8);
    check("overflow", overflow, moverflow);
    if (pulsed)   check("res_valid_rise", res_valid, 1);
    if (hold_rel) check("fir_valid_after_hold", fir_valid, 1);
  endtask

  task automatic push(input logic [15:0] v);
    wr_en = 1'b1; wr_data = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    bit done;
    done = 0;
    for (int i = 0; i < 600; i++) begin
      if (rnd) begin
        fir_ready = 1'($urandom_range(0, 1));
        res_ready = 1'($urandom_range(0, 1));
      end else begin
        fir_ready = 1'b1; res_ready = 1'b1;
      end
      if (sq.size() == 0 && rq.size() == 0 && fwait < 0 && !res_valid && !fir_valid) begin
        done = 1; break;
      end
      tick();
    end
    check("drain_done", done, 1);
  endtask

  initial begin
    @(negedge clock);

    // Single sample with fixed FIR latency
    do_reset();
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_fir_valid", fir_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    fir_ready = 1'b1; res_ready = 1'b1;
    push(16'h1234);
    check("single_fv_c1", fir_valid, 0);
    tick();
    check("single_fv_c2", fir_valid, 1);
    check("single_fin_c2", fir_in, 16'h1234);
    use_next = 1; next_fout = 38'h00_0000_ABCD;
    tick();
    check("single_fv_wait", fir_valid, 0);
    tick(); tick(); tick();
    check("single_res_data", res_data, 38'h00_0000_ABCD);
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("single_res_hold", res_data, 38'h00_0000_ABCD);
      check("single_res_valid", res_valid, 1);
    end
    res_ready = 1'b1;
    tick();
    check("single_idle", res_valid, 0);

    // Ordering and pointer wrap with random handshakes
    do_reset();
    rand_fir = 1;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 4; k++) begin
        fir_ready = 1'($urandom_range(0, 1));
        res_ready = 1'($urandom_range(0, 1));
        push(16'(b * 4 + k + 1));
      end
      for (int k = 0; k < int'($urandom_range(2, 6)); k++) begin
        fir_ready = 1'($urandom_range(0, 1));
        res_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    drain(1);
    check("rand_count_end", count, 0);
    rand_fir = 0;

    // Overflow at full
    do_reset();
    fir_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      push(16'(i));
      if (i == 8) check("ovf_full_at_8", full, 1);
    end
    check("ovf_count", count, 8);
    check("ovf_flag", overflow, 1);
    drain(0);
    check("ovf_sticky", overflow, 1);

    // Simultaneous write and pop at full
    do_reset();
    fir_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(16'(i + 32));
    fir_ready = 1'b1;
    push(16'h0100);
    check("simul_count", count, 8);
    check("simul_overflow", overflow, 0);
    drain(0);

    // Downstream backpressure with samples queued
    do_reset();
    fir_ready = 1'b1; res_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(16'(16'hA0 + i));
    for (int i = 0; i < 20 && !res_valid; i++) tick();
    check("bp_hold_reached", res_valid, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_res_data", res_data, (rq.size() != 0) ? rq[0] : 38'h0);
      check("bp_fir_valid", fir_valid, 0);
      check("bp_count", count, 3);
    end
    res_ready = 1'b1;
    tick();
    drain(0);

    // Reset while waiting on the FIR
    do_reset();
    fir_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(16'(16'h50 + i));
    fir_ready = 1'b1;
    tick();
    fir_ready = 1'b0;
    check("mid_count_wait", count, 4);
    do_reset();
    stray = 1;
    tick();
    check("mid_res_valid", res_valid, 0);
    check("mid_count", count, 0);
    check("mid_fir_valid", fir_valid, 0);
    tick();
    check("mid_res_valid2", res_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_sample_feeder.md
# fir_sample_feeder

Transmit-side companion for the FIR datapath. Buffers upstream samples in a small FIFO and presents them one at a time to the FIR over a valid/ready handshake. Captures each filter result into a holding register and offers it downstream with a second valid/ready handshake. Exactly one sample is in flight through the FIR at any time.

## Interface
Parameters:
- inwidth, 16, sample width (matches FIR input width)
- outwidth, 38, FIR result width
- depth, 8, FIFO entries (power of two)
- logdepth, 3, log2(depth)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  upstream write strobe
- wr_data  in  inwidth  upstream sample
- full  out  1  count == depth
- count  out  logdepth+1  FIFO occupancy, 0..depth
- overflow  out  1  sticky: a write was dropped because the FIFO was full
- fir_in  out  inwidth  sample presented to the FIR; equals the FIFO head
- fir_valid  out  1  fir_in is valid
- fir_ready  in  1  FIR accepts fir_in this cycle
- fir_out  in  outwidth  FIR result
- fir_out_valid  in  1  fir_out is valid (one-cycle pulse)
- res_data  out  outwidth  held result
- res_valid  out  1  res_data is valid
- res_ready  in  1  downstream accepts res_data

## Operation
- FIFO: circular buffer with rd_ptr/wr_ptr of logdepth bits; pointers wrap from depth-1 to 0; count is kept as a separate register.
- Write is accepted when wr_en and either not full, or a pop happens in the same cycle. If accepted while full with a simultaneous pop, count is unchanged.
- Write with wr_en while full and no pop: the data is dropped, FIFO state is unchanged, and overflow is set. overflow clears only on reset.
- Pop happens on the handshake: fir_valid and fir_ready.
- fir_in is driven combinationally from mem[rd_ptr]. It is stable while fir_valid is high.
- State machine (registered state):
  - IDLE: fir_valid=0, res_valid=0. Go to SEND when count != 0, using the registered count.
  - SEND: fir_valid=1. On fir_ready, pop and go to WAIT. fir_valid must not drop before the handshake.
  - WAIT: fir_valid=0. On fir_out_valid, load res_data from fir_out and go to HOLD.
  - HOLD: res_valid=1 and res_data is held constant. On res_ready, go to SEND if count != 0, else go to IDLE.
- fir_out_valid outside WAIT is ignored. fir_ready outside SEND is ignored.
- res_data passes fir_out through unmodified at full outwidth; the block does no arithmetic on it.

## Timing
- Reset values: state IDLE, rd_ptr=wr_ptr=0, count=0, full=0, overflow=0, fir_valid=0, res_valid=0, res_data=0. FIFO memory contents are don't-care.
- Reset mid-operation:
  - Discards every queued sample, the in-flight sample and any held result.
  - A fir_out_valid that arrives after reset is ignored, because state is IDLE.
- Latency:
  - A write at edge t into an empty FIFO in IDLE gives count=1 after t and fir_valid=1 after edge t+1.
  - res_valid rises the edge after fir_out_valid is sampled in WAIT.
  - From HOLD with res_ready and count != 0, fir_valid=1 on the next cycle.
- Throughput is one sample per FIR round trip plus 1 cycle (WAIT→HOLD) plus the downstream stall.
- count, full and overflow are registered and update on the edge that performs the write or pop.

## Test plan
- Single sample: after reset write 0x1234 at cycle 0 with fir_ready=1 -> fir_valid=1 and fir_in=0x1234 in cycle 2. Pulse fir_out_valid with fir_out=38'h00_0000_ABCD in cycle 5 -> res_valid=1 and res_data=38'h00_0000_ABCD from cycle 6 until res_ready.
- Ordering/wrap: write 12 samples 1..12 in bursts and drain them with random fir_ready, fir_out_valid and res_ready -> fir_in sequence is exactly 1..12, pointers wrap once, count returns to 0.
- Overflow: hold fir_ready=0 and write 9 samples -> full=1 after the 8th, the 9th is dropped, overflow=1 and count=8. Then release fir_ready -> values 1..8 are emitted.
- Simultaneous write/pop at full: count=8, in SEND, fir_ready=1 and wr_en=1 in the same cycle -> count stays 8, overflow stays 0, and the new sample later emerges last.
- Backpressure: hold res_ready=0 for 20 cycles in HOLD with 3 samples queued -> res_data stable, fir_valid=0, count stays 3. Release -> next fir_valid the following cycle.
- Reset mid-flight: in WAIT with 4 queued, assert reset 1 cycle, then pulse fir_out_valid -> count=0, res_valid stays 0, overflow=0.
